seq_divider: RTL and testbench



---
 rtl/alu_div_pkg.sv | 11 +
 rtl/seq_divider_if.sv | 27 ++
 rtl/div_trial_sub.sv | 13 +
 rtl/seq_divider.sv | 164 ++++++++++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_div_pkg.sv
// Shared constants for the sequential restoring divider.
package alu_div_pkg;
    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_if
    import alu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/div_trial_sub.sv
// One restoring-division step: trial subtract of the divisor from the shifted remainder.
module div_trial_sub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0]   shifted,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             nonneg
);
    // A non-negative trial always fits in WIDTH bits because rem < divisor on entry.
    assign nonneg = (shifted >= {1'b0, divisor});
    assign diff   = WIDTH'(shifted - {1'b0, divisor});
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake.
module seq_divider
    import alu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    logic [1:0]       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] rem, rem_d;
    logic [WIDTH-1:0] quo, quo_d;
    logic [WIDTH-1:0] abs_div, abs_div_d;
    logic [WIDTH-1:0] dvd_raw, dvd_raw_d;
    logic             neg_q, neg_q_d;
    logic             neg_r, neg_r_d;
    logic             ovf_pend, ovf_pend_d;
    logic             div0_pend, div0_pend_d;

    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             trial_ok;
    logic             a_neg, b_neg;

    assign shifted = {rem, quo[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .shifted (shifted),
        .divisor (abs_div),
        .diff    (trial),
        .nonneg  (trial_ok)
    );

    assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rem_d       = rem;
        quo_d       = quo;
        abs_div_d   = abs_div;
        dvd_raw_d   = dvd_raw;
        neg_q_d     = neg_q;
        neg_r_d     = neg_r;
        ovf_pend_d  = ovf_pend;
        div0_pend_d = div0_pend;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_d      = 1'b1;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    rem_d       = '0;
                    quo_d       = a_neg ? neg2c(bus.dividend) : bus.dividend;
                    abs_div_d   = b_neg ? neg2c(bus.divisor) : bus.divisor;
                    dvd_raw_d   = bus.dividend;
                    neg_q_d     = a_neg ^ b_neg;
                    neg_r_d     = a_neg;
                    ovf_pend_d  = bus.signed_op && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                  && (bus.divisor == {WIDTH{1'b1}});
                    div0_pend_d = (bus.divisor == '0);
                    cnt_d       = CW'(WIDTH - 1);
                    // Divide-by-zero still takes one busy cycle so results load at a single point.
                    state_d     = (bus.divisor == '0) ? ST_FIXUP : ST_RUN;
                end
            end
            ST_RUN: begin
                rem_d = trial_ok ? trial : shifted[WIDTH-1:0];
                quo_d = {quo[WIDTH-2:0], trial_ok};
                if (cnt == '0) begin
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            ST_FIXUP: begin
                if (div0_pend) begin
                    quotient_d  = WIDTH'(DIV0_QUOTIENT);
                    remainder_d = dvd_raw;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = neg_q ? neg2c(quo) : quo;
                    remainder_d = neg_r ? neg2c(rem) : rem;
                    ovf_d       = ovf_pend;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            abs_div     <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_pend    <= 1'b0;
            div0_pend   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            rem         <= rem_d;
            quo         <= quo_d;
            abs_div     <= abs_div_d;
            dvd_raw     <= dvd_raw_d;
            neg_q       <= neg_q_d;
            neg_r       <= neg_r_d;
            ovf_pend    <= ovf_pend_d;
            div0_pend   <= div0_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases plus random operands against an arithmetic model.
module tb_seq_divider;
    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic [15:0] last_q = '0;
    logic [15:0] last_r = '0;

    seq_divider_if #(.WIDTH(16)) bus();

    seq_divider #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int sa, sb_;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.cyc = 0;
        if (b == 16'h0) begin
            e.q   = 16'hFFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            sa  = int'($signed(a));
            sb_ = int'($signed(b));
            e.q = 16'(sa / sb_);
            e.r = 16'(sa % sb_);
            e.ovf = (sa == -32768) && (sb_ == -1);
        end
        return e;
    endfunction

    // Results monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(bus.quotient), 32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
                last_q = e.q;
                last_r = e.r;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        wait_idle();
        chk("hold_q", 32'(bus.quotient), 32'(last_q));
        chk("hold_r", 32'(bus.remainder), 32'(last_r));
        e = model(s, a, b);
        e.cyc = cyc + ((b == 16'h0) ? 2 : 18);
        sb.push_back(e);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.signed_op = 1'($urandom);
        bus.dividend  = 16'($urandom);
        bus.divisor   = 16'($urandom);
    endtask

    initial begin
        int n;
        int busy_cnt;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q", 32'(bus.quotient), 32'd0);
        chk("rst_r", 32'(bus.remainder), 32'd0);
        chk("rst_flags", 32'({bus.div_by_zero, bus.overflow}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned 100/7 with busy-window count (t+1..t+17 inclusive).
        issue(1'b0, 16'd100, 16'd7);
        busy_cnt = 0;
        n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd17);

        issue(1'b1, 16'hFF9C, 16'd7);
        issue(1'b1, 16'd7, 16'hFFFE);
        issue(1'b0, 16'h1234, 16'h0);
        issue(1'b1, 16'h1234, 16'h0);
        issue(1'b1, 16'h8000, 16'hFFFF);
        issue(1'b0, 16'h8000, 16'hFFFF);
        issue(1'b0, 16'hFFFF, 16'h8001);

        // Start while busy is dropped without queuing.
        issue(1'b0, 16'hFFFF, 16'h0001);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd10;
        bus.divisor  = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;

        // Reset in RUN aborts with no done and clears results.
        issue(1'b0, 16'd1000, 16'd9);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        last_q = '0;
        last_r = '0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_q", 32'(bus.quotient), 32'd0);
        chk("abort_r", 32'(bus.remainder), 32'd0);
        repeat (25) @(negedge clk);
        issue(1'b0, 16'd50, 16'd5);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] a, b;
            logic        s;
            s = 1'($urandom);
            a = 16'($urandom);
            case ($urandom_range(0, 5))
                0: b = 16'h0;
                1: b = 16'($urandom_range(1, 15));
                2: b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = 16'h8000;
                b = 16'hFFFF;
            end
            issue(s, a, b);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
